// File: rtl/cpu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// controller states and the default datapath width.
package cpu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiplier / restoring divider on magnitudes, with the
// two's-complement sign fix applied combinationally to the final result.
module muldiv_datapath
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               div0_q, div0_d;

    logic               sgn;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;

        sgn   = op_is_signed(op_i);
        a_mag = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

        sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

        if (load_i) begin
            is_div_d = op_is_div(op_i);
            neg_d    = sgn & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_d   = sgn & a_i[WIDTH-1];
            div0_d   = (b_i == '0);
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend.
            opnd_d   = op_is_div(op_i) ? b_mag : a_mag;
            acc_d    = {{WIDTH{1'b0}}, op_is_div(op_i) ? a_mag : b_mag};
        end else if (step_i) begin
            if (is_div_q) begin
                // diff[WIDTH] is the borrow of the trial subtract: set means restore.
                acc_d = diff[WIDTH]
                      ? {acc_q[2*WIDTH-2:0], 1'b0}
                      : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = acc_q[0]
                      ? {sum, acc_q[WIDTH-1:1]}
                      : {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            hi_o = rem;
            lo_o = div0_q ? {WIDTH{1'b1}} : quo;
        end else begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide controller: sequences WIDTH iterations plus a fix-up
// cycle, owns HI/LO, and stalls the pipeline while an operation is in flight.
module ex_muldiv
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_data_i,
    input  logic [WIDTH-1:0] rt_data_i,
    input  logic             kill_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             load, step;

    assign load = (state_q == IDLE) && start_i && !kill_i;
    assign step = (state_q == BUSY) && !kill_i;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (load),
        .step_i  (step),
        .op_i    (op_i),
        .a_i     (rs_data_i),
        .b_i     (rt_data_i),
        .hi_o    (res_hi),
        .lo_o    (res_lo)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (kill_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!kill_i) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the two register operands and a decoded op when the instruction in EX is MULT/MULTU/DIV/DIVU.
- Iterates one bit per cycle and writes the HI/LO architectural registers.
- Drives a stall (busy_o) back to the hazard/PC logic until the result is committed.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_n_i  input  1  asynchronous, active-low reset
- start_i  input  1  request: EX holds a mul/div instruction
- op_i  input  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- rs_data_i  input  WIDTH  operand A (multiplicand / dividend), from ID/EX RDData0
- rt_data_i  input  WIDTH  operand B (multiplier / divisor), from ID/EX RDData1
- kill_i  input  1  flush: abort any operation in progress
- busy_o  output  1  high while an operation is in flight; pipeline stall request
- done_o  output  1  one-cycle pulse when HI/LO have just been updated
- hi_o  output  WIDTH  HI register (product upper half / remainder)
- lo_o  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - state=IDLE, counter=0
  - hi_o=0, lo_o=0, busy_o=0, done_o=0
  - Working registers cleared.
- States and transitions:
  - IDLE: start_i=1 and kill_i=0 at edge E0 → BUSY, counter=0. Operands latched at E0: magnitudes for signed ops, raw values for unsigned ops. The result sign is recorded: for MULT, sign(A) xor sign(B); for DIV, quotient sign = sign(A) xor sign(B) and remainder sign = sign(A).
  - BUSY: one iteration per edge, E1..E32 (counter 0..31). Multiply uses shift-add into a 2*WIDTH accumulator. Divide is restoring: shift the remainder left, trial-subtract the divisor, set the quotient bit. At the edge where counter=WIDTH-1 → FIX.
  - FIX (edge E33): apply two's-complement sign correction to the result, write hi_o/lo_o, set done_o=1 for exactly one cycle, → IDLE.
- Latency and handshake:
  - busy_o is a registered decode, equal to (state != IDLE). It is high for the 33 cycles following E0.
  - done_o is high in the cycle following E33, and busy_o is low in that same cycle.
  - start_i is ignored while busy_o=1; the upstream stall keeps the instruction in EX.
  - start_i=1 in the done_o cycle (state IDLE) is accepted and starts a new operation.
- Result rules:
  - MULT/MULTU: {hi_o,lo_o} = full 2*WIDTH product.
  - DIV/DIVU: lo_o=quotient, hi_o=remainder. Signed division truncates toward zero.
  - Divide by zero (B=0): lo_o = all ones, hi_o = A (raw operand). Latency is still the full 33 cycles.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF, DIV): lo_o=0x80000000, hi_o=0.
- kill_i:
  - In BUSY or FIX, kill_i=1 at an edge → IDLE. HI/LO are unchanged and no done_o pulse is produced.
  - kill_i has priority over start_i in the same cycle.
- Reset asserted mid-operation: immediate return to the reset values; no partial HI/LO write.
- HI/LO change only in FIX and on reset.

Decomposition:
- Shared package (cpu_pkg): op encoding constants OP_MULT, OP_MULTU, OP_DIV, OP_DIVU; state enum IDLE/BUSY/FIX; WIDTH default.
- One natural sub-module: muldiv_datapath, holding the accumulator/remainder register, the shift-add/trial-subtract logic and the sign fix. ex_muldiv keeps the FSM, counter and the HI/LO registers.

Test Plan:
- Reset mid-BUSY (assert rst_n_i at cycle 10 after start) → hi_o=lo_o=0, busy_o=0 immediately (asynchronous), no done_o.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles: hi_o=0xFFFFFFFE, lo_o=0x00000001; busy_o high exactly 33 cycles; done_o exactly 1 cycle.
- MULT -7 × 3 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB.
- DIV -7 / 2 → lo_o=0xFFFFFFFD (−3), hi_o=0xFFFFFFFF (−1). DIVU 100/7 → lo_o=14, hi_o=2.
- DIVU 5 / 0 → lo_o=0xFFFFFFFF, hi_o=5. DIV 0x80000000 / 0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- kill_i at iteration 15, then start_i MULTU 6×7 in the next cycle → no done_o for the killed op, prior HI/LO held; new op yields hi_o=0, lo_o=42. Back-to-back start_i in the done_o cycle is accepted.
